// File: rtl/regsel_burst.sv
// Register-select decoder for a 2**SELW register file, with operand latches and a burst
// sequencer that walks a register range one register per cycle for save/restore.
module regsel_burst #(
    parameter int SELW = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 oe,
    input  logic                 load,
    input  logic [1:0]           oe_src_sel,
    input  logic                 load_src_sel,
    input  logic [SELW-1:0]      useq_oe_sel,
    input  logic [SELW-1:0]      useq_load_sel,
    input  logic                 ir_load,
    input  logic [3*SELW-1:0]    ir_ops,
    input  logic                 burst_start,
    input  logic                 burst_dir,
    input  logic [SELW-1:0]      burst_first,
    input  logic [SELW-1:0]      burst_last,
    input  logic                 burst_stall,
    output logic [2**SELW-1:0]   reg_oes,
    output logic [2**SELW-1:0]   reg_loads,
    output logic                 burst_busy,
    output logic                 burst_done,
    output logic [SELW-1:0]      burst_index,
    output logic                 conflict
);

    localparam int NREGS = 2**SELW;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [SELW-1:0] op0Q, op1Q, op2Q;
    logic [1:0]      stateQ;
    logic [SELW-1:0] burstIdxQ;
    logic            burstDirQ;
    logic [SELW-1:0] burstLastQ;
    logic            conflictQ;

    logic [SELW-1:0] oeSel;
    logic [SELW-1:0] loadSel;
    logic            runMode;
    logic            collision;

    function automatic logic [NREGS-1:0] decodeSel(input logic [SELW-1:0] sel);
        logic [NREGS-1:0] vec;
        vec      = '0;
        vec[sel] = 1'b1;
        return vec;
    endfunction

    assign runMode = (stateQ == ST_RUN);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        oeSel = useq_oe_sel;
        case (oe_src_sel)
            2'b00:   oeSel = useq_oe_sel;
            2'b01:   oeSel = op0Q;
            2'b10:   oeSel = op1Q;
            default: oeSel = op2Q;
        endcase
    end

    assign loadSel   = load_src_sel ? op0Q : useq_load_sel;
    assign collision = !runMode && oe && load && (oeSel == loadSel);

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op0Q <= '0;
            op1Q <= '0;
            op2Q <= '0;
        end else if (ir_load) begin
            op0Q <= ir_ops[SELW-1:0];
            op1Q <= ir_ops[2*SELW-1:SELW];
            op2Q <= ir_ops[3*SELW-1:2*SELW];
        end
    end

    // A new collision outranks a clear requested in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflictQ <= 1'b0;
        end else if (collision) begin
            conflictQ <= 1'b1;
        end else if (ir_load) begin
            conflictQ <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ     <= ST_IDLE;
            burstIdxQ  <= '0;
            burstDirQ  <= 1'b0;
            burstLastQ <= '0;
        end else begin
            case (stateQ)
                ST_IDLE: begin
                    if (burst_start) begin
                        burstIdxQ  <= burst_first;
                        burstDirQ  <= burst_dir;
                        burstLastQ <= burst_last;
                        stateQ     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Index wraps naturally through NREGS-1 to 0.
                    if (!burst_stall) begin
                        if (burstIdxQ == burstLastQ) begin
                            stateQ <= ST_DONE;
                        end else begin
                            burstIdxQ <= burstIdxQ + SELW'(1);
                        end
                    end
                end
                ST_DONE: stateQ <= ST_IDLE;
                default: stateQ <= ST_IDLE;
            endcase
        end
    end

    // Strobes are forced low while reset is held, even if oe/load are still requested.
    always_comb begin
        reg_oes   = '0;
        reg_loads = '0;
        if (!reset) begin
            if (runMode) begin
                if (burstDirQ) begin
                    reg_loads = decodeSel(burstIdxQ);
                end else begin
                    reg_oes = decodeSel(burstIdxQ);
                end
            end else begin
                if (oe) begin
                    reg_oes = decodeSel(oeSel);
                end
                if (load) begin
                    reg_loads = decodeSel(loadSel);
                end
            end
        end
    end

    assign burst_busy  = runMode;
    assign burst_done  = (stateQ == ST_DONE);
    assign burst_index = burstIdxQ;
    assign conflict    = conflictQ;

endmodule

// File: tb/tb_regsel_burst.sv
// Directed bench for regsel_burst: normal decode, conflict flag and bursts at SELW=3,
// plus a wrapping burst at SELW=4. Inputs change on the falling edge, outputs checked 1ns later.
module tb_regsel_burst;

    logic clk = 1'b0;
    logic reset;

    // SELW = 3 instance
    logic        oe, load, load_src_sel, ir_load, burst_start, burst_dir, burst_stall;
    logic [1:0]  oe_src_sel;
    logic [2:0]  useq_oe_sel, useq_load_sel, burst_first, burst_last, burst_index;
    logic [8:0]  ir_ops;
    logic [7:0]  reg_oes, reg_loads;
    logic        burst_busy, burst_done, conflict;

    // SELW = 4 instance
    logic        burstStart4, burstDir4;
    logic [3:0]  burstFirst4, burstLast4, burstIndex4;
    logic [15:0] regOes4, regLoads4;
    logic        burstBusy4, burstDone4, conflict4;

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    regsel_burst #(.SELW(3)) dut3 (
        .clk(clk), .reset(reset), .oe(oe), .load(load),
        .oe_src_sel(oe_src_sel), .load_src_sel(load_src_sel),
        .useq_oe_sel(useq_oe_sel), .useq_load_sel(useq_load_sel),
        .ir_load(ir_load), .ir_ops(ir_ops),
        .burst_start(burst_start), .burst_dir(burst_dir),
        .burst_first(burst_first), .burst_last(burst_last), .burst_stall(burst_stall),
        .reg_oes(reg_oes), .reg_loads(reg_loads), .burst_busy(burst_busy),
        .burst_done(burst_done), .burst_index(burst_index), .conflict(conflict)
    );

    regsel_burst #(.SELW(4)) dut4 (
        .clk(clk), .reset(reset), .oe(1'b0), .load(1'b0),
        .oe_src_sel(2'b00), .load_src_sel(1'b0),
        .useq_oe_sel(4'd0), .useq_load_sel(4'd0),
        .ir_load(1'b0), .ir_ops(12'd0),
        .burst_start(burstStart4), .burst_dir(burstDir4),
        .burst_first(burstFirst4), .burst_last(burstLast4), .burst_stall(1'b0),
        .reg_oes(regOes4), .reg_loads(regLoads4), .burst_busy(burstBusy4),
        .burst_done(burstDone4), .burst_index(burstIndex4), .conflict(conflict4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    logic [7:0]  saveExp [4] = '{8'h02, 8'h04, 8'h08, 8'h10};
    logic [7:0]  wrapExp [5] = '{8'h40, 8'h80, 8'h80, 8'h01, 8'h02};
    logic        wrapStall [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [15:0] wide4Exp [4] = '{16'h4000, 16'h8000, 16'h0001, 16'h0002};

    initial begin
        reset = 1'b1;
        oe = 0; load = 0; load_src_sel = 0; ir_load = 0; burst_start = 0;
        burst_dir = 0; burst_stall = 0; oe_src_sel = 2'b00;
        useq_oe_sel = 0; useq_load_sel = 0; burst_first = 0; burst_last = 0; ir_ops = '0;
        burstStart4 = 0; burstDir4 = 0; burstFirst4 = 0; burstLast4 = 0;

        // Reset state
        #1;
        check("rst_oes", reg_oes, 0);
        check("rst_loads", reg_loads, 0);
        nextCycle(); nextCycle();
        reset = 1'b0;
        #1;
        check("rst_busy", burst_busy, 0);
        check("rst_done", burst_done, 0);
        check("rst_index", burst_index, 0);
        check("rst_conflict", conflict, 0);
        check("rst_oes4", regOes4, 0);

        // 1: operand latch, decode still uses old latches during ir_load
        nextCycle();
        ir_ops = {3'd5, 3'd3, 3'd6};
        ir_load = 1; oe = 1; oe_src_sel = 2'b10; load = 0; load_src_sel = 1;
        #1;
        check("irload_old_oes", reg_oes, 8'h01);
        check("irload_old_loads", reg_loads, 8'h00);
        nextCycle();
        ir_load = 0; load = 1;
        #1;
        check("op1_oes", reg_oes, 8'h08);
        check("op0_loads", reg_loads, 8'h40);
        oe_src_sel = 2'b11;
        #1;
        check("op2_oes", reg_oes, 8'h20);
        nextCycle();
        check("no_conflict", conflict, 0);

        // 2: collision sets sticky conflict, ir_load clears it
        oe_src_sel = 2'b00; load_src_sel = 0; useq_oe_sel = 2; useq_load_sel = 2;
        #1;
        check("coll_oes", reg_oes, 8'h04);
        check("coll_loads", reg_loads, 8'h04);
        check("coll_before_edge", conflict, 0);
        nextCycle();
        oe = 0; load = 0;
        #1;
        check("conflict_set", conflict, 1);
        nextCycle();
        check("conflict_sticky", conflict, 1);
        ir_load = 1;
        nextCycle();
        ir_load = 0;
        #1;
        check("conflict_cleared", conflict, 0);

        // 3: burst save 1..4, oe/load requests ignored while running
        nextCycle();
        burst_start = 1; burst_dir = 0; burst_first = 1; burst_last = 4;
        #1;
        check("save_idle_busy", burst_busy, 0);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            burst_start = 0;
            oe = (i < 3); load = (i < 3); useq_oe_sel = 0; useq_load_sel = 7;
            #1;
            check($sformatf("save_oes_%0d", i), reg_oes, saveExp[i]);
            check($sformatf("save_loads_%0d", i), reg_loads, 0);
            check($sformatf("save_busy_%0d", i), burst_busy, 1);
            check($sformatf("save_done_%0d", i), burst_done, 0);
        end
        nextCycle();
        #1;
        check("save_done", burst_done, 1);
        check("save_done_busy", burst_busy, 0);
        check("save_done_index", burst_index, 4);
        check("save_done_oes", reg_oes, 0);
        nextCycle();
        check("save_done_once", burst_done, 0);

        // 4: restore 6..1 with wrap and one stall at index 7
        burst_start = 1; burst_dir = 1; burst_first = 6; burst_last = 1;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            burst_start = 0;
            burst_stall = wrapStall[i];
            #1;
            check($sformatf("wrap_loads_%0d", i), reg_loads, wrapExp[i]);
            check($sformatf("wrap_oes_%0d", i), reg_oes, 0);
            check($sformatf("wrap_done_%0d", i), burst_done, 0);
        end
        nextCycle();
        burst_stall = 0;
        #1;
        check("wrap_done", burst_done, 1);
        check("wrap_done_loads", reg_loads, 0);

        // 5: async reset mid-burst
        nextCycle();
        burst_start = 1; burst_dir = 0; burst_first = 1; burst_last = 6;
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            burst_start = 0;
        end
        #1;
        check("pre_reset_oes", reg_oes, 8'h08);
        reset = 1;
        #1;
        check("async_reset_oes", reg_oes, 0);
        check("async_reset_busy", burst_busy, 0);
        check("async_reset_index", burst_index, 0);
        nextCycle();
        reset = 0;
        #1;
        check("post_reset_done", burst_done, 0);
        nextCycle();
        check("post_reset_done2", burst_done, 0);
        burst_start = 1; burst_first = 2; burst_last = 3;
        nextCycle();
        burst_start = 0;
        #1;
        check("rerun_oes_0", reg_oes, 8'h04);
        nextCycle();
        check("rerun_oes_1", reg_oes, 8'h08);
        nextCycle();
        check("rerun_done", burst_done, 1);

        // 6: SELW=4 wrap burst, burst_start ignored in RUN and DONE
        nextCycle();
        burstStart4 = 1; burstDir4 = 0; burstFirst4 = 14; burstLast4 = 1;
        nextCycle();
        burstFirst4 = 5; burstDir4 = 1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nextCycle();
            #1;
            check($sformatf("w4_oes_%0d", i), regOes4, wide4Exp[i]);
            check($sformatf("w4_loads_%0d", i), regLoads4, 0);
            check($sformatf("w4_busy_%0d", i), burstBusy4, 1);
        end
        nextCycle();
        burstFirst4 = 3; burstLast4 = 3;
        #1;
        check("w4_done", burstDone4, 1);
        check("w4_done_index", burstIndex4, 1);
        nextCycle();
        #1;
        check("w4_done_start_ignored", burstBusy4, 0);
        check("w4_idle_index", burstIndex4, 1);
        nextCycle();
        burstStart4 = 0;
        #1;
        check("w4_start_after_done_busy", burstBusy4, 1);
        check("w4_start_after_done_loads", regLoads4, 16'h0008);
        nextCycle();
        check("w4_second_done", burstDone4, 1);
        check("w4_conflict", conflict4, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numChecks, numFails);
        $finish;
    end

endmodule
